// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: FSM state encoding,
// the Mem2RegSEL "no load" code and a small load-detect helper.
package hazard_ctrl_pkg;

    // Controller states; the encoding is fixed so that waveforms and
    // debug dumps read the same across builds.
    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_LOAD_WAIT = 2'd1,
        ST_MEM_HOLD  = 2'd2
    } hz_state_e;

    // Mem2RegSEL value meaning "result does not come from memory".
    localparam logic [1:0] MEM2REG_NONE = 2'b00;

    // Width of the load-latency down-counter (LOAD_LAT is at most 7).
    localparam int LCNT_W = 3;

    // A stage carries a load when its writeback select is not "none".
    function automatic logic is_load(input logic [1:0] sel);
        return sel != MEM2REG_NONE;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Register-dependency comparator: flags when either source register of
// the Decode instruction equals a destination register. Register 0 is
// hard-wired to zero, so it never creates a dependency.
module hazard_match
    import hazard_ctrl_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] i_src_a,
    input  logic [ADDR_W-1:0] i_src_b,
    input  logic [ADDR_W-1:0] i_dst,
    output logic              o_hit
);

    logic w_dst_nz;

    assign w_dst_nz = (i_dst != '0);
    assign o_hit    = w_dst_nz & ((i_src_a == i_dst) | (i_src_b == i_dst));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls lasting LOAD_LAT cycles,
// a whole-pipeline freeze while data memory is busy, taken-branch flush
// of IF/ID, and a saturating count of Decode-stall cycles.
// Optional feature: define BRANCH_HAZARD_EN to also stall a branch in
// Decode whose operands are still being produced in EX (any write) or
// by a load in MEM.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] RsAddr_D,
    input  logic [ADDR_W-1:0] RtAddr_D,
    input  logic [ADDR_W-1:0] RegAddr3_E,
    input  logic [ADDR_W-1:0] RegAddr3_M,
    input  logic              RegWriteEN_E,
    input  logic              RegWriteEN_M,
    input  logic [1:0]        Mem2RegSEL_E,
    input  logic [1:0]        Mem2RegSEL_M,
    input  logic              Beq,
    input  logic              Bne,
    input  logic              BranchTaken_D,
    input  logic              MemBusy,
    output logic              Stall_F,
    output logic              Stall_D,
    output logic              Stall_E,
    output logic              Stall_M,
    output logic              Flush_D,
    output logic              Flush_E,
    output logic [CNT_W-1:0]  StallCnt
);

    // Value loaded into the down-counter on a fresh load-use hit; the hit
    // cycle itself is the first stall cycle.
    localparam logic [LCNT_W-1:0] LOAD_INIT = LCNT_W'(LOAD_LAT - 1);

    hz_state_e         r_state;
    hz_state_e         r_ret_state;
    hz_state_e         w_state_nxt;
    hz_state_e         w_ret_nxt;
    hz_state_e         w_eff_state;
    logic [LCNT_W-1:0] r_load_cnt;
    logic [LCNT_W-1:0] w_load_cnt_nxt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              w_e_match;
    logic              w_load_use;
    logic              w_br_hazard;
    logic              w_hold_d;

    hazard_match #(.ADDR_W(ADDR_W)) u_match_e (
        .i_src_a (RsAddr_D),
        .i_src_b (RtAddr_D),
        .i_dst   (RegAddr3_E),
        .o_hit   (w_e_match)
    );

    assign w_load_use = is_load(Mem2RegSEL_E) & RegWriteEN_E & w_e_match;

`ifdef BRANCH_HAZARD_EN
    logic w_m_match;

    hazard_match #(.ADDR_W(ADDR_W)) u_match_m (
        .i_src_a (RsAddr_D),
        .i_src_b (RtAddr_D),
        .i_dst   (RegAddr3_M),
        .o_hit   (w_m_match)
    );

    // Branch compares in Decode, so its operands must already be final:
    // anything written by EX, or a load still in MEM, is not yet available.
    assign w_br_hazard = (Beq | Bne) &
                         ((RegWriteEN_E & w_e_match) |
                          (is_load(Mem2RegSEL_M) & RegWriteEN_M & w_m_match));
`else
    // Branch operands are forwarded elsewhere; these inputs are unused here.
    logic w_unused_branch;

    assign w_br_hazard     = 1'b0;
    assign w_unused_branch = ^{Beq, Bne, RegWriteEN_M, Mem2RegSEL_M, RegAddr3_M};
`endif

    // Behaviour this cycle: reset behaves as RUN, and leaving MEM_HOLD
    // resumes the frozen state immediately so no cycle is lost.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        w_eff_state = r_state;
        if (RST) begin
            w_eff_state = ST_RUN;
        end else if (r_state == ST_MEM_HOLD) begin
            w_eff_state = r_ret_state;
        end
    end

    // Next-state logic: memory freeze first, then load-latency tracking.
    always_comb begin
        w_state_nxt    = w_eff_state;
        w_ret_nxt      = r_ret_state;
        w_load_cnt_nxt = r_load_cnt;
        if (MemBusy) begin
            w_state_nxt = ST_MEM_HOLD;
            w_ret_nxt   = w_eff_state;
        end else begin
            case (w_eff_state)
                ST_RUN: begin
                    if (w_load_use) begin
                        w_load_cnt_nxt = LOAD_INIT;
                        w_state_nxt    = (LOAD_LAT > 1) ? ST_LOAD_WAIT : ST_RUN;
                    end
                end
                ST_LOAD_WAIT: begin
                    // A new hit here is the same load; the count is not reloaded.
                    w_load_cnt_nxt = r_load_cnt - LCNT_W'(1);
                    if (r_load_cnt <= LCNT_W'(1)) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (RST) begin
            r_state     <= ST_RUN;
            r_ret_state <= ST_RUN;
            r_load_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ret_state <= w_ret_nxt;
            r_load_cnt  <= w_load_cnt_nxt;
        end
    end

    // Stall/flush outputs: memory freeze holds everything and never
    // flushes; otherwise a Decode hold bubbles EX and suppresses branch flush.
    always_comb begin
        Stall_F  = 1'b0;
        Stall_D  = 1'b0;
        Stall_E  = 1'b0;
        Stall_M  = 1'b0;
        Flush_D  = 1'b0;
        Flush_E  = 1'b0;
        w_hold_d = 1'b0;
        if (MemBusy) begin
            Stall_F = 1'b1;
            Stall_D = 1'b1;
            Stall_E = 1'b1;
            Stall_M = 1'b1;
        end else begin
            w_hold_d = (w_eff_state == ST_LOAD_WAIT) |
                       ((w_eff_state == ST_RUN) & w_load_use) |
                       w_br_hazard;
            Stall_F  = w_hold_d;
            Stall_D  = w_hold_d;
            Flush_E  = w_hold_d;
            Flush_D  = BranchTaken_D & ~w_hold_d;
        end
    end

    // Saturating count of cycles in which Decode is held.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cnt <= '0;
        end else if (Stall_D && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign StallCnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a combinational vector table on a
// LOAD_LAT=1 instance, then multi-cycle sequences on a LOAD_LAT=3 instance
// with a 3-bit stall counter. Branch-hazard expectations follow the
// BRANCH_HAZARD_EN build macro.
module tb_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [4:0] RsAddr_D, RtAddr_D, RegAddr3_E, RegAddr3_M;
    logic       RegWriteEN_E, RegWriteEN_M;
    logic [1:0] Mem2RegSEL_E, Mem2RegSEL_M;
    logic       Beq, Bne, BranchTaken_D, MemBusy;

    logic        d1_sf, d1_sd, d1_se, d1_sm, d1_fd, d1_fe;
    logic [15:0] d1_cnt;
    logic        d3_sf, d3_sd, d3_se, d3_sm, d3_fd, d3_fe;
    logic [2:0]  d3_cnt;

    int checks   = 0;
    int failures = 0;

    // {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E}
    typedef struct {
        logic [4:0] rs, rt, rd_e, rd_m;
        logic       we_e, we_m;
        logic [1:0] sel_e, sel_m;
        logic       beq, bne, taken, busy;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[$];

    logic s2_d  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic s1_d  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic bz    [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic bz_sd [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic bz_se [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic bz_fe [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    always #5 CLK = ~CLK;

    hazard_ctrl #(.ADDR_W(5), .LOAD_LAT(1), .CNT_W(16)) dut1 (
        .CLK(CLK), .RST(RST),
        .RsAddr_D(RsAddr_D), .RtAddr_D(RtAddr_D),
        .RegAddr3_E(RegAddr3_E), .RegAddr3_M(RegAddr3_M),
        .RegWriteEN_E(RegWriteEN_E), .RegWriteEN_M(RegWriteEN_M),
        .Mem2RegSEL_E(Mem2RegSEL_E), .Mem2RegSEL_M(Mem2RegSEL_M),
        .Beq(Beq), .Bne(Bne), .BranchTaken_D(BranchTaken_D), .MemBusy(MemBusy),
        .Stall_F(d1_sf), .Stall_D(d1_sd), .Stall_E(d1_se), .Stall_M(d1_sm),
        .Flush_D(d1_fd), .Flush_E(d1_fe), .StallCnt(d1_cnt)
    );

    hazard_ctrl #(.ADDR_W(5), .LOAD_LAT(3), .CNT_W(3)) dut3 (
        .CLK(CLK), .RST(RST),
        .RsAddr_D(RsAddr_D), .RtAddr_D(RtAddr_D),
        .RegAddr3_E(RegAddr3_E), .RegAddr3_M(RegAddr3_M),
        .RegWriteEN_E(RegWriteEN_E), .RegWriteEN_M(RegWriteEN_M),
        .Mem2RegSEL_E(Mem2RegSEL_E), .Mem2RegSEL_M(Mem2RegSEL_M),
        .Beq(Beq), .Bne(Bne), .BranchTaken_D(BranchTaken_D), .MemBusy(MemBusy),
        .Stall_F(d3_sf), .Stall_D(d3_sd), .Stall_E(d3_se), .Stall_M(d3_sm),
        .Flush_D(d3_fd), .Flush_E(d3_fe), .StallCnt(d3_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd_e, input logic we_e, input logic [1:0] sel_e,
                           input logic [4:0] rd_m, input logic we_m, input logic [1:0] sel_m,
                           input logic beq, input logic bne, input logic taken,
                           input logic busy, input logic [5:0] exp);
        vec_t v;
        v.rs = rs; v.rt = rt; v.rd_e = rd_e; v.we_e = we_e; v.sel_e = sel_e;
        v.rd_m = rd_m; v.we_m = we_m; v.sel_m = sel_m;
        v.beq = beq; v.bne = bne; v.taken = taken; v.busy = busy; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic clear_inputs();
        RsAddr_D = '0; RtAddr_D = '0; RegAddr3_E = '0; RegAddr3_M = '0;
        RegWriteEN_E = 1'b0; RegWriteEN_M = 1'b0;
        Mem2RegSEL_E = 2'b00; Mem2RegSEL_M = 2'b00;
        Beq = 1'b0; Bne = 1'b0; BranchTaken_D = 1'b0; MemBusy = 1'b0;
    endtask

    // lw r5 in EX, add r6,r5,r7 in Decode
    task automatic set_load_hit();
        Mem2RegSEL_E = 2'b01; RegWriteEN_E = 1'b1; RegAddr3_E = 5'd5;
        RsAddr_D = 5'd5; RtAddr_D = 5'd7;
    endtask

    // EX holds a bubble after the flush; Decode keeps its instruction
    task automatic clear_e();
        Mem2RegSEL_E = 2'b00; RegWriteEN_E = 1'b0; RegAddr3_E = '0;
    endtask

    // Leaves time at posedge+1 with RST low and all inputs idle
    task automatic do_reset();
        @(posedge CLK); #1;
        clear_inputs();
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge CLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clear_inputs();

        // rs, rt, rd_e, we_e, sel_e, rd_m, we_m, sel_m, beq, bne, taken, busy, exp
        add_vec(0, 0, 0, 0, 2'd0, 0, 0, 2'd0, 0, 0, 0, 0, 6'b000000); // idle
        add_vec(5, 7, 5, 1, 2'd1, 0, 0, 2'd0, 0, 0, 0, 0, 6'b110001); // load-use on rs
        add_vec(7, 5, 5, 1, 2'd1, 0, 0, 2'd0, 0, 0, 0, 0, 6'b110001); // load-use on rt
        add_vec(0, 0, 0, 1, 2'd1, 0, 0, 2'd0, 0, 0, 0, 0, 6'b000000); // load to r0
        add_vec(5, 7, 5, 0, 2'd1, 0, 0, 2'd0, 0, 0, 0, 0, 6'b000000); // load, no write
        add_vec(5, 7, 5, 1, 2'd0, 0, 0, 2'd0, 0, 0, 0, 0, 6'b000000); // ALU producer
        add_vec(1, 2, 0, 0, 2'd0, 0, 0, 2'd0, 1, 0, 1, 0, 6'b000010); // taken branch
        add_vec(5, 7, 5, 1, 2'd1, 0, 0, 2'd0, 0, 0, 1, 0, 6'b110001); // stalled branch
        add_vec(5, 7, 5, 1, 2'd1, 0, 0, 2'd0, 0, 0, 1, 1, 6'b111100); // mem busy wins
        add_vec(1, 2, 0, 0, 2'd0, 0, 0, 2'd0, 1, 0, 1, 0, 6'b000010); // after busy
        add_vec(5, 7, 5, 1, 2'd2, 0, 0, 2'd0, 0, 0, 0, 0, 6'b110001); // sel=2 is load
`ifdef BRANCH_HAZARD_EN
        add_vec(3, 4, 3, 1, 2'd0, 0, 0, 2'd0, 1, 0, 1, 0, 6'b110001); // beq vs EX write
        add_vec(3, 4, 0, 0, 2'd0, 4, 1, 2'd1, 1, 0, 0, 0, 6'b110001); // beq vs MEM load
`else
        add_vec(3, 4, 3, 1, 2'd0, 0, 0, 2'd0, 1, 0, 1, 0, 6'b000010);
        add_vec(3, 4, 0, 0, 2'd0, 4, 1, 2'd1, 1, 0, 0, 0, 6'b000000);
`endif
        add_vec(3, 4, 0, 0, 2'd0, 4, 1, 2'd1, 0, 0, 0, 0, 6'b000000); // no branch
        add_vec(3, 4, 0, 0, 2'd0, 4, 1, 2'd0, 0, 1, 0, 0, 6'b000000); // bne vs MEM ALU
        add_vec(0, 0, 0, 0, 2'd0, 0, 1, 2'd1, 0, 1, 0, 0, 6'b000000); // bne vs r0 load

        // Reset state
        do_reset();
        @(negedge CLK);
        check("reset_flags_d1", {d1_sf, d1_sd, d1_se, d1_sm, d1_fd, d1_fe}, 6'b0);
        check("reset_flags_d3", {d3_sf, d3_sd, d3_se, d3_sm, d3_fd, d3_fe}, 6'b0);
        check("reset_cnt_d1", d1_cnt, 0);
        check("reset_cnt_d3", d3_cnt, 0);

        // Vector table on the LOAD_LAT=1 instance
        next_cycle();
        for (int i = 0; i < vecs.size(); i++) begin
            RsAddr_D = vecs[i].rs; RtAddr_D = vecs[i].rt;
            RegAddr3_E = vecs[i].rd_e; RegWriteEN_E = vecs[i].we_e; Mem2RegSEL_E = vecs[i].sel_e;
            RegAddr3_M = vecs[i].rd_m; RegWriteEN_M = vecs[i].we_m; Mem2RegSEL_M = vecs[i].sel_m;
            Beq = vecs[i].beq; Bne = vecs[i].bne; BranchTaken_D = vecs[i].taken; MemBusy = vecs[i].busy;
            @(negedge CLK);
            check($sformatf("vec%0d_flags", i), {d1_sf, d1_sd, d1_se, d1_sm, d1_fd, d1_fe}, vecs[i].exp);
            next_cycle();
        end
        clear_inputs();
        @(negedge CLK);
        check("branch_flush_one_cycle", d1_fd, 0);

        // Load-use stall length: 1 cycle at LOAD_LAT=1, 3 cycles at LOAD_LAT=3
        do_reset();
        for (int c = 0; c < 4; c++) begin
            if (c == 0) set_load_hit();
            else clear_e();
            @(negedge CLK);
            check($sformatf("lat1_stall_d_c%0d", c), d1_sd, s1_d[c]);
            check($sformatf("lat3_stall_d_c%0d", c), d3_sd, s2_d[c]);
            check($sformatf("lat3_flush_e_c%0d", c), d3_fe, s2_d[c]);
            next_cycle();
        end
        @(negedge CLK);
        check("lat1_stallcnt", d1_cnt, 1);
        check("lat3_stallcnt", d3_cnt, 3);

        // Persisting hit during LOAD_WAIT must not reload the counter
        do_reset();
        for (int c = 0; c < 4; c++) begin
            if (c < 3) set_load_hit();
            else clear_e();
            @(negedge CLK);
            check($sformatf("noreload_stall_d_c%0d", c), d3_sd, s2_d[c]);
            next_cycle();
        end

        // MemBusy for 2 cycles during the second load-stall cycle
        do_reset();
        for (int c = 0; c < 6; c++) begin
            if (c == 0) set_load_hit();
            else clear_e();
            MemBusy = bz[c];
            @(negedge CLK);
            check($sformatf("busy_stall_d_c%0d", c), d3_sd, bz_sd[c]);
            check($sformatf("busy_stall_e_c%0d", c), d3_se, bz_se[c]);
            check($sformatf("busy_stall_m_c%0d", c), d3_sm, bz_se[c]);
            check($sformatf("busy_flush_e_c%0d", c), d3_fe, bz_fe[c]);
            next_cycle();
        end
        @(negedge CLK);
        check("busy_stallcnt_lat3", d3_cnt, 5);
        check("busy_stallcnt_lat1", d1_cnt, 3);

        // Reset in the middle of LOAD_WAIT abandons the stall
        do_reset();
        set_load_hit();
        @(negedge CLK);
        check("rst_mid_first_stall", d3_sd, 1);
        next_cycle();
        clear_e();
        RST = 1'b1;
        @(negedge CLK);
        check("rst_mid_during_rst", d3_sd, 0);
        next_cycle();
        RST = 1'b0;
        @(negedge CLK);
        check("rst_mid_after_stall_d", d3_sd, 0);
        check("rst_mid_after_cnt", d3_cnt, 0);
        next_cycle();
        @(negedge CLK);
        check("rst_mid_no_residual", d3_sd, 0);

        // Stall counter saturation on the 3-bit instance
        do_reset();
        MemBusy = 1'b1;
        repeat (9) @(posedge CLK);
        #1;
        MemBusy = 1'b0;
        @(negedge CLK);
        check("sat_cnt_lat3", d3_cnt, 7);
        check("sat_cnt_lat1", d1_cnt, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter ADDR_W, default 5: register address width.
REQ-002 Parameter LOAD_LAT, default 1, range 1..7: cycles a load result trails the EX stage before it is usable in D.
REQ-003 Parameter CNT_W, default 16: stall performance counter width.
REQ-004 CLK  in  1: single clock; all state updates on rising edge.
REQ-005 RST  in  1: synchronous reset, active-high.
REQ-006 RsAddr_D, RtAddr_D  in  ADDR_W: source registers of the instruction in Decode.
REQ-007 RegAddr3_E, RegAddr3_M  in  ADDR_W: destination registers in EX and MEM.
REQ-008 RegWriteEN_E, RegWriteEN_M  in  1: destination write enables in EX and MEM.
REQ-009 Mem2RegSEL_E, Mem2RegSEL_M  in  2: nonzero means load.
REQ-010 Beq, Bne  in  1: branch in Decode; BranchTaken_D  in  1: branch resolved taken in Decode.
REQ-011 MemBusy  in  1: data memory not ready; the whole pipeline must freeze.
REQ-012 Stall_F, Stall_D  out  1: hold PC and IF/ID register.
REQ-013 Stall_E, Stall_M  out  1: hold ID/EX and EX/MEM registers.
REQ-014 Flush_D, Flush_E  out  1: bubble the IF/ID and ID/EX registers.
REQ-015 StallCnt  out  CNT_W: count of cycles with Stall_D high.

Function
REQ-016 Match(a,x) is true only when a==x and x!=0; register 0 never causes a hazard.
REQ-017 Load-use hit: Mem2RegSEL_E!=0, RegWriteEN_E=1, and Match(RsAddr_D or RtAddr_D, RegAddr3_E).
REQ-018 States: RUN, LOAD_WAIT, MEM_HOLD; RST forces RUN.
REQ-019 RUN with load-use hit: Stall_F=Stall_D=Flush_E=1 in that cycle; load counter := LOAD_LAT-1; next state LOAD_WAIT if LOAD_LAT>1, else RUN.
REQ-020 LOAD_WAIT: Stall_F=Stall_D=Flush_E=1; counter decrements each cycle; exit to RUN on the cycle the counter reads 1, so total stall is exactly LOAD_LAT cycles.
REQ-021 MemBusy=1 in any state: all four Stall_* = 1, both flushes = 0, next state MEM_HOLD; the load counter and LOAD_WAIT progress are frozen.
REQ-022 MEM_HOLD: leave on the first cycle MemBusy=0, returning to the frozen state (RUN or LOAD_WAIT) with the counter unchanged.
REQ-023 Flush_D = BranchTaken_D & ~Stall_D & ~MemBusy; a stalled branch never flushes.
REQ-024 Flush_E and Stall_E are never both 1; MemBusy priority over load-use, load-use priority over branch hazard.
REQ-025 Load-use hit arriving while already in LOAD_WAIT does not reload the counter.
REQ-026 StallCnt increments by 1 each cycle Stall_D=1 and saturates at all-ones.
REQ-027 All Stall_*/Flush_* are combinational from state and inputs; state and counters are registered.

Reset
REQ-028 RST=1 at a clock edge: state RUN, load counter 0, StallCnt 0; outputs during and after that cycle follow RUN with current inputs.
REQ-029 RST mid-LOAD_WAIT or mid-MEM_HOLD abandons the stall with no residual cycles.

Configuration
REQ-030 BRANCH_HAZARD_EN defined: with Beq|Bne, stall D and F (Flush_E=1) when RegWriteEN_E & Match(Rs/Rt, RegAddr3_E), or Mem2RegSEL_M!=0 & RegWriteEN_M & Match(Rs/Rt, RegAddr3_M); one cycle per hit, no state change.
REQ-031 BRANCH_HAZARD_EN undefined: branch operands are never a stall source; only load-use and MemBusy stall.

Structure
REQ-032 Shared package holds the state enum encoding (RUN=0, LOAD_WAIT=1, MEM_HOLD=2) and the Mem2RegSEL "none" constant 2'b00.
REQ-033 One sub-module, hazard_match, implementing Match() on two sources and one destination; instantiated per comparison.

Verification
REQ-034 LOAD_LAT=1: lw to r5 in E, add r6,r5,r7 in D -> Stall_D=Flush_E=1 for exactly 1 cycle, StallCnt=1.
REQ-035 LOAD_LAT=3, same hit -> Stall_D high 3 consecutive cycles, then 0; StallCnt=3.
REQ-036 LOAD_LAT=3, MemBusy high 2 cycles during second stall cycle -> all Stall_* high, flushes 0, then 2 more load-stall cycles (total Stall_D=5).
REQ-037 lw to r0 with reader of r0 -> no stall; BranchTaken_D=1, no hazard -> Flush_D=1 one cycle.
REQ-038 BRANCH_HAZARD_EN on: beq r3,r4 with add to r3 in E -> 1-cycle stall, Flush_D=0 that cycle; macro off -> no stall.
REQ-039 RST asserted in LOAD_WAIT cycle 2 of 3 -> next cycle Stall_D=0, StallCnt=0.
